// File: rtl/red_pitaya_daisy_align_pkg.sv
// rtl/red_pitaya_daisy_align_pkg.sv - shared daisy-link constants and aligner state encoding
package red_pitaya_daisy_align_pkg;

   // Link word width on both the TX serializer and RX deserializer side
   localparam int unsigned WORD_W = 16;

   // Training word the far-end transmitter repeats while in training mode
   localparam logic [WORD_W-1:0] DAISY_TRAIN_PAT = 16'h00FF;

   // Aligner FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HUNT    = 2'd1,
      ST_CONFIRM = 2'd2,
      ST_LOCKED  = 2'd3
   } daisy_state_e;

endpackage

// File: rtl/red_pitaya_daisy_align.sv
// rtl/red_pitaya_daisy_align.sv - daisy-link RX word aligner (slip hunt, lock confirm, aligned pass-through)
module red_pitaya_daisy_align
   import red_pitaya_daisy_align_pkg::*;
#(
   parameter logic [WORD_W-1:0] TRAIN_PAT = DAISY_TRAIN_PAT,
   parameter int unsigned       MATCH_N   = 8,
   parameter int unsigned       ERR_W     = 16
) (
   input  logic              par_clk_i,
   input  logic              par_rstn_i,
   input  logic              cfg_en_i,
   input  logic              cfg_train_i,
   input  logic              stat_clr_i,
   input  logic              raw_dv_i,
   input  logic [WORD_W-1:0] raw_dat_i,
   output logic              par_dv_o,
   output logic [WORD_W-1:0] par_dat_o,
   output logic              cfg_trained_o,
   output logic [3:0]        stat_slip_o,
   output logic [ERR_W-1:0]  stat_err_o
);

   // Pick 16 bits out of {previous word, current word} starting at bit 'slip'
   function automatic logic [WORD_W-1:0] window(input logic [2*WORD_W-1:0] cat,
                                                input logic [3:0]          slip);
      return cat[slip +: WORD_W];
   endfunction

   daisy_state_e      state_q, state_d;
   logic [3:0]        slip_q, slip_d;
   logic [7:0]        match_q, match_d;
   logic              trained_q, trained_d;
   logic [WORD_W-1:0] prev_q, prev_d;
   logic              train_prev_q, train_prev_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              par_dv_q, par_dv_d;
   logic [WORD_W-1:0] par_dat_q, par_dat_d;

   logic [WORD_W-1:0] aligned;
   logic              is_match;
   logic              train_rise;
   logic              err_inc;

   assign aligned    = window({prev_q, raw_dat_i}, slip_q);
   assign is_match   = (aligned == TRAIN_PAT);
   assign train_rise = cfg_train_i & ~train_prev_q;

   // Next-state logic: slip hunt, match confirmation, locked error counting / data pass
   always_comb begin
      state_d      = state_q;
      slip_d       = slip_q;
      match_d      = match_q;
      trained_d    = trained_q;
      prev_d       = raw_dv_i ? raw_dat_i : prev_q;
      train_prev_d = cfg_train_i;
      par_dv_d     = 1'b0;
      par_dat_d    = par_dat_q;
      err_inc      = 1'b0;

      if (!cfg_en_i) begin
         state_d   = ST_IDLE;
         slip_d    = 4'd0;
         match_d   = 8'd0;
         trained_d = 1'b0;
         par_dat_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cfg_train_i) state_d = ST_HUNT;
            end
            ST_HUNT, ST_CONFIRM: begin
               if (!cfg_train_i) begin
                  state_d = ST_IDLE;
                  slip_d  = 4'd0;
                  match_d = 8'd0;
               end else if (raw_dv_i) begin
                  if (!is_match) begin
                     // Mismatch anywhere in hunt/confirm: try the next rotation
                     state_d = ST_HUNT;
                     slip_d  = slip_q + 4'd1;
                     match_d = 8'd0;
                  end else if (state_q == ST_HUNT) begin
                     state_d = ST_CONFIRM;
                     match_d = 8'd1;
                  end else begin
                     match_d = match_q + 8'd1;
                     if (match_q + 8'd1 == 8'(MATCH_N)) begin
                        state_d   = ST_LOCKED;
                        trained_d = 1'b1;
                     end
                  end
               end
            end
            ST_LOCKED: begin
               if (train_rise) begin
                  // Retrain from the current slip rather than from zero
                  state_d   = ST_HUNT;
                  trained_d = 1'b0;
                  match_d   = 8'd0;
               end else if (raw_dv_i) begin
                  if (cfg_train_i) begin
                     err_inc = ~is_match;
                  end else begin
                     par_dv_d  = 1'b1;
                     par_dat_d = aligned;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (stat_clr_i)
         err_d = '0;
      else if (err_inc && (err_q != {ERR_W{1'b1}}))
         err_d = err_q + ERR_W'(1);
      else
         err_d = err_q;
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
      if (!par_rstn_i) begin
         state_q      <= ST_IDLE;
         slip_q       <= 4'd0;
         match_q      <= 8'd0;
         trained_q    <= 1'b0;
         prev_q       <= '0;
         train_prev_q <= 1'b0;
         err_q        <= '0;
         par_dv_q     <= 1'b0;
         par_dat_q    <= '0;
      end else begin
         state_q      <= state_d;
         slip_q       <= slip_d;
         match_q      <= match_d;
         trained_q    <= trained_d;
         prev_q       <= prev_d;
         train_prev_q <= train_prev_d;
         err_q        <= err_d;
         par_dv_q     <= par_dv_d;
         par_dat_q    <= par_dat_d;
      end
   end

   assign par_dv_o      = par_dv_q;
   assign par_dat_o     = par_dat_q;
   assign cfg_trained_o = trained_q;
   assign stat_slip_o   = slip_q;
   assign stat_err_o    = err_q;

endmodule

// File: tb/tb_red_pitaya_daisy_align.sv
// tb/tb_red_pitaya_daisy_align.sv - scoreboard bench for the daisy RX word aligner
module tb_red_pitaya_daisy_align;

   logic        par_clk_i = 1'b0;
   logic        par_rstn_i = 1'b0;
   logic        cfg_en_i = 1'b0;
   logic        cfg_train_i = 1'b0;
   logic        stat_clr_i = 1'b0;
   logic        raw_dv_i = 1'b0;
   logic [15:0] raw_dat_i = 16'h0000;
   logic        par_dv_o;
   logic [15:0] par_dat_o;
   logic        cfg_trained_o;
   logic [3:0]  stat_slip_o;
   logic [15:0] stat_err_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] exp_q[$];

   red_pitaya_daisy_align dut (
      .par_clk_i     (par_clk_i),
      .par_rstn_i    (par_rstn_i),
      .cfg_en_i      (cfg_en_i),
      .cfg_train_i   (cfg_train_i),
      .stat_clr_i    (stat_clr_i),
      .raw_dv_i      (raw_dv_i),
      .raw_dat_i     (raw_dat_i),
      .par_dv_o      (par_dv_o),
      .par_dat_o     (par_dat_o),
      .cfg_trained_o (cfg_trained_o),
      .stat_slip_o   (stat_slip_o),
      .stat_err_o    (stat_err_o)
   );

   always #5 par_clk_i = ~par_clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] w);
      raw_dv_i  = 1'b1;
      raw_dat_i = w;
      @(negedge par_clk_i);
      raw_dv_i  = 1'b0;
   endtask

   task automatic send_exp(input logic [15:0] w, input logic [15:0] e);
      exp_q.push_back(e);
      send(w);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge par_clk_i);
   endtask

   // Monitor: every presented word must match the head of the expected queue
   initial begin
      forever begin
         @(negedge par_clk_i);
         if (par_dv_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_word: got dv=1 dat=%h expected no word", par_dat_o);
            end else begin
               check("par_dat_o", {16'h0, par_dat_o}, {16'h0, exp_q.pop_front()});
            end
         end
      end
   end

   // Time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(2);
      check("rst_dv", {31'h0, par_dv_o}, 32'h0);
      check("rst_dat", {16'h0, par_dat_o}, 32'h0);
      par_rstn_i = 1'b1;
      idle(1);
      check("reset_trained", {31'h0, cfg_trained_o}, 32'h0);
      check("reset_slip", {28'h0, stat_slip_o}, 32'h0);
      check("reset_err", {16'h0, stat_err_o}, 32'h0);

      // Disabled: raw words are ignored
      cfg_train_i = 1'b1;
      repeat (3) send(16'h07F8);
      check("dis_dv", {31'h0, par_dv_o}, 32'h0);
      check("dis_slip", {28'h0, stat_slip_o}, 32'h0);
      check("dis_trained", {31'h0, cfg_trained_o}, 32'h0);

      // Clean hunt: raw = rotl(00FF,3), lock on the 11th word
      cfg_en_i = 1'b1;
      idle(1);
      for (int i = 1; i <= 11; i++) begin
         send(16'h07F8);
         check($sformatf("clean_slip_w%0d", i), {28'h0, stat_slip_o}, (i < 3) ? i : 3);
         check($sformatf("clean_trained_w%0d", i), {31'h0, cfg_trained_o}, (i == 11) ? 1 : 0);
      end

      // Back to idle, then hunt again with a mismatch in CONFIRM
      cfg_en_i = 1'b0;
      idle(1);
      check("en_off_slip", {28'h0, stat_slip_o}, 32'h0);
      check("en_off_trained", {31'h0, cfg_trained_o}, 32'h0);
      cfg_en_i = 1'b1;
      idle(1);
      repeat (6) send(16'h07F8);
      send(16'h0000);
      check("confirm_miss_slip", {28'h0, stat_slip_o}, 32'd4);
      check("confirm_miss_trained", {31'h0, cfg_trained_o}, 32'h0);
      for (int n = 8; n <= 30; n++) begin
         send(16'h07F8);
         check($sformatf("relock_slip_w%0d", n), {28'h0, stat_slip_o},
               (n <= 22) ? ((n - 3) % 16) : 3);
         check($sformatf("relock_trained_w%0d", n), {31'h0, cfg_trained_o}, (n == 30) ? 1 : 0);
      end

      // Locked with training held: count mismatches, clear wins over increment
      repeat (5) send(16'h1234);
      check("err_5", {16'h0, stat_err_o}, 32'd5);
      check("err_slip", {28'h0, stat_slip_o}, 32'd3);
      check("err_trained", {31'h0, cfg_trained_o}, 32'h1);
      stat_clr_i = 1'b1;
      send(16'h1234);
      stat_clr_i = 1'b0;
      check("err_clr", {16'h0, stat_err_o}, 32'd0);
      repeat (2) send(16'h1234);
      check("err_2", {16'h0, stat_err_o}, 32'd2);

      // Pass-through at slip 3: aligned = {prev[2:0], raw[15:3]}
      cfg_train_i = 1'b0;
      idle(1);
      send_exp(16'h07F8, 16'h80FF);
      send_exp(16'h07F8, 16'h00FF);
      send_exp(16'h1230, 16'h0246);
      send_exp(16'h8001, 16'h1000);
      send_exp(16'h0000, 16'h2000);
      idle(1);
      check("gap_dv", {31'h0, par_dv_o}, 32'h0);
      check("gap_dat_hold", {16'h0, par_dat_o}, 32'h2000);
      check("pass_err_hold", {16'h0, stat_err_o}, 32'd2);

      // cfg_en dropped mid-stream
      send_exp(16'h07F8, 16'h00FF);
      cfg_en_i = 1'b0;
      send(16'h07F8);
      check("drop_trained", {31'h0, cfg_trained_o}, 32'h0);
      check("drop_slip", {28'h0, stat_slip_o}, 32'h0);
      check("drop_dv", {31'h0, par_dv_o}, 32'h0);
      check("drop_dat", {16'h0, par_dat_o}, 32'h0);
      check("drop_err_hold", {16'h0, stat_err_o}, 32'd2);

      // Async reset mid-CONFIRM
      cfg_en_i    = 1'b1;
      cfg_train_i = 1'b1;
      idle(1);
      repeat (6) send(16'h07F8);
      check("confirm_slip", {28'h0, stat_slip_o}, 32'd3);
      check("confirm_trained", {31'h0, cfg_trained_o}, 32'h0);
      @(posedge par_clk_i);
      #2;
      par_rstn_i = 1'b0;
      #1;
      check("async_slip", {28'h0, stat_slip_o}, 32'h0);
      check("async_err", {16'h0, stat_err_o}, 32'h0);
      check("async_trained", {31'h0, cfg_trained_o}, 32'h0);
      check("async_dv", {31'h0, par_dv_o}, 32'h0);
      check("async_dat", {16'h0, par_dat_o}, 32'h0);
      idle(2);
      par_rstn_i = 1'b1;
      idle(2);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
